// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite types and constants for the bus slaves.
//   htrans_t      - transfer type encoding (IDLE, BUSY, NONSEQ, SEQ)
//   hsize_t       - legal transfer sizes (BYTE, HALF, WORD)
//   HRESP_*       - response encodings
//   slave_state_t - data-phase state of an SRAM-style slave
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } slave_state_t;

endpackage

// File: rtl/ahb_byte_strobe.sv
// ahb_byte_strobe: decodes transfer size and byte offset into 32-bit lane strobes.
//   size       in  3  hsize of the transfer
//   offset     in  2  haddr[1:0]
//   strb       out 4  byte lanes touched by the transfer (0 for illegal sizes)
//   misaligned out 1  half not on a 2-byte boundary, or word not on a 4-byte boundary
import ahb_pkg::*;

module ahb_byte_strobe (
    input  logic [2:0] size,
    input  logic [1:0] offset,
    output logic [3:0] strb,
    output logic       misaligned
);

    always_comb begin
        strb       = '0;
        misaligned = 1'b0;
        case (hsize_t'(size))
            HSIZE_BYTE: strb = 4'b0001 << offset;
            HSIZE_HALF: begin
                strb       = offset[1] ? 4'b1100 : 4'b0011;
                misaligned = offset[0];
            end
            HSIZE_WORD: begin
                strb       = 4'b1111;
                misaligned = (offset != 2'b00);
            end
            default: begin
                strb       = '0;
                misaligned = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite subordinate in front of a word-organised SRAM.
//   clk, reset       clock (rising edge) and asynchronous active-low reset
//   hsel, haddr, htrans, hwrite, hsize, hprot   address phase (hprot ignored)
//   hwdata           write data, sampled at the end of the data phase
//   hready_in        bus-level ready from the mux
//   hready_out       this slave's ready
//   hresp            0 = OKAY, 1 = ERROR (two-cycle response)
//   hrdata           registered read data, loaded when the read is accepted
import ahb_pkg::*;

module ahb_sram_slave #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned READ_ONLY   = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [3:0]  hprot,
    input  logic [31:0] hwdata,
    input  logic        hready_in,
    output logic        hready_out,
    output logic        hresp,
    output logic [31:0] hrdata
);

    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [33:0] LIMIT     = 34'(DEPTH) << 2;

    slave_state_t   state;
    logic [3:0]     wait_cnt;
    logic           pend_wr;
    logic [AW-1:0]  pend_word;
    logic [3:0]     pend_strb;
    logic [31:0]    mem [DEPTH];

    logic [3:0]     strb;
    logic           misaligned;
    logic           accept;
    logic           illegal;
    logic           wr_commit;
    logic [AW-1:0]  word_idx;
    logic [31:0]    rd_word;
    htrans_t        trans;
    logic           unused_hprot;

    assign unused_hprot = ^hprot;

    ahb_byte_strobe u_strobe (
        .size       (hsize),
        .offset     (haddr[1:0]),
        .strb       (strb),
        .misaligned (misaligned)
    );

    assign trans    = htrans_t'(htrans);
    assign word_idx = haddr[AW+1:2];

    // hready_out gates acceptance too, so a stalled own data phase can never
    // swallow a new address phase even if the bus ready disagrees.
    assign accept  = hsel && hready_in && hready_out &&
                     (trans == HTRANS_NONSEQ || trans == HTRANS_SEQ);
    assign illegal = (hsize > 3'd2) || misaligned ||
                     ({2'b00, haddr} >= LIMIT) ||
                     (hwrite && (READ_ONLY != 0));

    // A pending write only exists for legal transfers, so IDLE with a pending
    // write is exactly the final OKAY data cycle.
    assign wr_commit = pend_wr && (state == ST_IDLE);

    // Read path merges the lanes of a write completing on the same edge.
    always_comb begin
        rd_word = mem[word_idx];
        for (int unsigned i = 0; i < 4; i++) begin
            if (wr_commit && (pend_word == word_idx) && pend_strb[i]) begin
                rd_word[8*i +: 8] = hwdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_commit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (pend_strb[i]) begin
                    mem[pend_word][8*i +: 8] <= hwdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            hready_out <= 1'b1;
            hresp      <= HRESP_OKAY;
            hrdata     <= '0;
            wait_cnt   <= '0;
            pend_wr    <= 1'b0;
            pend_word  <= '0;
            pend_strb  <= '0;
        end else begin
            if (wr_commit) begin
                pend_wr <= 1'b0;
            end
            if (accept) begin
                if (illegal) begin
                    state      <= ST_ERR1;
                    hready_out <= 1'b0;
                    hresp      <= HRESP_ERROR;
                end else begin
                    pend_wr   <= hwrite;
                    pend_word <= word_idx;
                    pend_strb <= strb;
                    hresp     <= HRESP_OKAY;
                    if (!hwrite) begin
                        hrdata <= rd_word;
                    end
                    if (WAIT_STATES > 0) begin
                        state      <= ST_WAIT;
                        hready_out <= 1'b0;
                        wait_cnt   <= WAIT_LOAD;
                    end else begin
                        state      <= ST_IDLE;
                        hready_out <= 1'b1;
                    end
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        hready_out <= 1'b1;
                        hresp      <= HRESP_OKAY;
                    end
                    ST_WAIT: begin
                        if (wait_cnt == 4'd0) begin
                            state      <= ST_IDLE;
                            hready_out <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt - 4'd1;
                        end
                    end
                    ST_ERR1: begin
                        state      <= ST_ERR2;
                        hready_out <= 1'b1;
                        hresp      <= HRESP_ERROR;
                    end
                    ST_ERR2: begin
                        state      <= ST_IDLE;
                        hready_out <= 1'b1;
                        hresp      <= HRESP_OKAY;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
module tb_ahb_sram_slave;

    localparam int NU    = 3;
    localparam int DEPTH = 64;

    function automatic int ws_of(int u);
        case (u)
            0:       return 0;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic bit ro_of(int u);
        return (u == 2);
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NU-1:0] rst_n, hsel, hrdy_in, hrdy_out, hresp_o;
    logic [31:0]   haddr, hwdata;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [3:0]    hprot;
    logic [31:0]   hrdata_o [NU];

    ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(0), .READ_ONLY(0)) dut0 (
        .clk(clk), .reset(rst_n[0]), .hsel(hsel[0]), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata),
        .hready_in(hrdy_in[0]), .hready_out(hrdy_out[0]), .hresp(hresp_o[0]), .hrdata(hrdata_o[0]));

    ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(3), .READ_ONLY(0)) dut1 (
        .clk(clk), .reset(rst_n[1]), .hsel(hsel[1]), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata),
        .hready_in(hrdy_in[1]), .hready_out(hrdy_out[1]), .hresp(hresp_o[1]), .hrdata(hrdata_o[1]));

    ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(2), .READ_ONLY(1)) dut2 (
        .clk(clk), .reset(rst_n[2]), .hsel(hsel[2]), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata),
        .hready_in(hrdy_in[2]), .hready_out(hrdy_out[2]), .hresp(hresp_o[2]), .hrdata(hrdata_o[2]));

    int checks = 0;
    int errors = 0;

    task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // Transaction-level model: each accepted transfer expands into the list of
    // response cycles it owns; memory is updated when a write's last cycle ends.
    typedef struct {
        bit         rdy;
        bit         resp;
        bit         fin_wr;
        int         word;
        logic [3:0] strb;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mem_m [NU][DEPTH];
    bit          mk    [NU][DEPTH];
    logic [31:0] rd_m  [NU];
    bit          rd_known [NU];
    logic        exp_rdy  [NU];
    logic        exp_resp [NU];
    int          cur;
    logic [31:0] cur_wdata;
    bit          last_acc;
    bit          chk_en;

    function automatic ent_t mk_ent(bit rdy, bit resp, bit fw, int word, logic [3:0] strb);
        ent_t e;
        e.rdy = rdy; e.resp = resp; e.fin_wr = fw; e.word = word; e.strb = strb;
        return e;
    endfunction

    task automatic model_reset(int u);
        rd_m[u]     = '0;
        rd_known[u] = 1'b1;
        exp_rdy[u]  = 1'b1;
        exp_resp[u] = 1'b0;
        if (u == cur) q.delete();
    endtask

    task automatic model_edge();
        int         u;
        ent_t       e;
        bit         rdy, acc, bad;
        int         nb, w;
        logic [3:0] sb;
        u   = cur;
        rdy = exp_rdy[u];
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.fin_wr) begin
                for (int i = 0; i < 4; i++)
                    if (e.strb[i]) mem_m[u][e.word][8*i +: 8] = hwdata[8*i +: 8];
                if (e.strb == 4'hF) mk[u][e.word] = 1'b1;
            end
        end
        acc = hsel[u] && htrans[1] && rdy;
        if (acc) begin
            bad = 1'b0;
            sb  = '0;
            if (hsize > 3'd2) bad = 1'b1;
            else begin
                nb = 1 << hsize;
                if ((haddr % nb) != 0) bad = 1'b1;
                sb = 4'(((1 << nb) - 1) << haddr[1:0]);
            end
            if (haddr >= 4 * DEPTH) bad = 1'b1;
            if (hwrite && ro_of(u)) bad = 1'b1;
            w = int'(haddr[7:2]);
            if (bad) begin
                q.push_back(mk_ent(1'b0, 1'b1, 1'b0, 0, 4'h0));
                q.push_back(mk_ent(1'b1, 1'b1, 1'b0, 0, 4'h0));
            end else begin
                repeat (ws_of(u)) q.push_back(mk_ent(1'b0, 1'b0, 1'b0, 0, 4'h0));
                q.push_back(mk_ent(1'b1, 1'b0, hwrite, w, sb));
                if (!hwrite) begin
                    rd_m[u]     = mem_m[u][w];
                    rd_known[u] = mk[u][w];
                end
            end
        end
        last_acc = acc;
        if (q.size() > 0) begin
            exp_rdy[u]  = q[0].rdy;
            exp_resp[u] = q[0].resp;
        end else begin
            exp_rdy[u]  = 1'b1;
            exp_resp[u] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int u = 0; u < NU; u++) begin
                check32($sformatf("u%0d hready_out", u), 32'(hrdy_out[u]), 32'(exp_rdy[u]));
                check32($sformatf("u%0d hresp", u), 32'(hresp_o[u]), 32'(exp_resp[u]));
                if (rd_known[u]) check32($sformatf("u%0d hrdata", u), hrdata_o[u], rd_m[u]);
            end
        end
    end

    task automatic step(bit sel, logic [1:0] tr, bit wr, logic [2:0] sz, logic [31:0] a, logic [31:0] wd);
        @(negedge clk);
        hwdata    = cur_wdata;
        hsel      = '0;
        hsel[cur] = sel;
        htrans    = tr;
        hwrite    = wr;
        hsize     = sz;
        haddr     = a;
        hprot     = 4'($urandom);
        for (int u = 0; u < NU; u++) hrdy_in[u] = exp_rdy[u];
        @(posedge clk);
        #1;
        model_edge();
        if (last_acc && wr) cur_wdata = wd;
    endtask

    task automatic idle(int n);
        repeat (n) step(1'b0, 2'b00, 1'b0, 3'd2, 32'h0, 32'h0);
    endtask

    task automatic issue(bit wr, logic [2:0] sz, logic [31:0] a, logic [31:0] wd);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            step(1'b1, 2'b10, wr, sz, a, wd);
            done = last_acc;
        end
        if (!done) check32("accept_timeout", 32'(done), 32'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && q.size() > 0; k++) idle(1);
        idle(1);
    endtask

    task automatic init_words();
        for (int w = 0; w < DEPTH; w++) issue(1'b1, 3'd2, 32'(w * 4), $urandom);
        drain();
    endtask

    task automatic rand_phase(int n);
        bit          sel, wr;
        logic [1:0]  tr;
        logic [2:0]  sz;
        logic [31:0] a;
        int          r;
        for (int i = 0; i < n; i++) begin
            sel = ($urandom_range(0, 9) != 0);
            tr  = 2'($urandom);
            wr  = 1'($urandom);
            r   = $urandom_range(0, 9);
            sz  = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'($urandom_range(3, 7));
            a   = $urandom_range(0, 4 * DEPTH + 15);
            if ($urandom_range(0, 3) != 0 && sz <= 3'd2) a = a & ~((32'd1 << sz) - 32'd1);
            step(sel, tr, wr, sz, a, $urandom);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int cnt;

    initial begin
        hsel = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2; haddr = '0;
        hwdata = '0; hprot = '0; hrdy_in = '1; rst_n = '0;
        cur = 0; cur_wdata = '0; chk_en = 1'b0; last_acc = 1'b0;
        for (int u = 0; u < NU; u++) model_reset(u);
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < NU; u++) begin
            check32("reset hready_out", 32'(hrdy_out[u]), 32'd1);
            check32("reset hresp", 32'(hresp_o[u]), 32'd0);
            check32("reset hrdata", hrdata_o[u], 32'h0);
        end
        #1 rst_n = '1;
        chk_en = 1'b1;

        // ---------------- unit 0: zero wait states ----------------
        cur = 0;
        init_words();
        issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        issue(1'b0, 3'd2, 32'h10, 32'h0);
        check32("fwd word read", hrdata_o[0], 32'hDEADBEEF);
        issue(1'b1, 3'd2, 32'h20, 32'h0000_0000);
        issue(1'b1, 3'd0, 32'h21, 32'h5555_AA55);
        issue(1'b1, 3'd1, 32'h22, 32'h1234_6666);
        issue(1'b0, 3'd2, 32'h20, 32'h0);
        check32("byte/half lanes", hrdata_o[0], 32'h1234_AA00);
        idle(1);

        issue(1'b0, 3'd2, 32'h2, 32'h0);
        check32("err1 hready_out", 32'(hrdy_out[0]), 32'd0);
        check32("err1 hresp", 32'(hresp_o[0]), 32'd1);
        idle(1);
        check32("err2 hready_out", 32'(hrdy_out[0]), 32'd1);
        check32("err2 hresp", 32'(hresp_o[0]), 32'd1);
        issue(1'b0, 3'd2, 32'h10, 32'h0);
        check32("accept in err2 hresp", 32'(hresp_o[0]), 32'd0);
        check32("accept in err2 hrdata", hrdata_o[0], 32'hDEADBEEF);

        issue(1'b1, 3'd2, 32'(4 * DEPTH), 32'hFFFF_FFFF);
        check32("oob write hresp", 32'(hresp_o[0]), 32'd1);
        drain();
        issue(1'b0, 3'd2, 32'h0, 32'h0);
        idle(1);

        cur_wdata = 32'h0BAD_0BAD;
        step(1'b1, 2'b00, 1'b1, 3'd2, 32'h10, 32'h0BAD_0BAD);
        check32("idle hready_out", 32'(hrdy_out[0]), 32'd1);
        step(1'b1, 2'b01, 1'b1, 3'd2, 32'h10, 32'h0BAD_0BAD);
        check32("busy hresp", 32'(hresp_o[0]), 32'd0);
        idle(1);
        issue(1'b0, 3'd2, 32'h10, 32'h0);
        check32("no write on idle/busy", hrdata_o[0], 32'hDEADBEEF);
        rand_phase(300);
        drain();

        // ---------------- unit 1: three wait states ----------------
        cur = 1;
        init_words();
        issue(1'b0, 3'd2, 32'h0, 32'h0);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (hrdy_out[1] == 1'b0) begin
                cnt++;
                idle(1);
            end else begin
                break;
            end
        end
        check32("wait cycles", 32'(cnt), 32'd3);
        drain();

        issue(1'b1, 3'd2, 32'h40, 32'hCAFE_F00D);
        idle(1);
        rst_n[1] = 1'b0;
        #1;
        check32("async reset hready_out", 32'(hrdy_out[1]), 32'd1);
        check32("async reset hresp", 32'(hresp_o[1]), 32'd0);
        check32("async reset hrdata", hrdata_o[1], 32'h0);
        model_reset(1);
        @(negedge clk);
        #1 rst_n[1] = 1'b1;
        issue(1'b0, 3'd2, 32'h40, 32'h0);
        check32("abandoned write", hrdata_o[1], mem_m[1][16]);
        drain();
        rand_phase(200);
        drain();

        // ---------------- unit 2: read-only, two wait states ----------------
        cur = 2;
        issue(1'b1, 3'd2, 32'h0, 32'h1111_2222);
        check32("ro write hresp", 32'(hresp_o[2]), 32'd1);
        drain();
        issue(1'b0, 3'd2, 32'h4, 32'h0);
        drain();
        rand_phase(100);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
